// File: rtl/channel_entry_alloc_pkg.sv
// Shared constants and pointer helpers for the five-entry channel allocator.
package channel_entry_alloc_pkg;

  localparam int CH_ENTRY_NUM = 5;
  localparam int CH_PTR_W     = 3;

  // Advance a ring pointer by one, wrapping from the last entry back to 0.
  // Out-of-range inputs also fold to 0 so a pointer can never escape 0..4.
  function automatic logic [CH_PTR_W-1:0] ptr_inc(input logic [CH_PTR_W-1:0] ptr);
    logic [CH_PTR_W-1:0] nxt;
    if (ptr >= CH_PTR_W'(CH_ENTRY_NUM - 1)) begin
      nxt = {CH_PTR_W{1'b0}};
    end else begin
      nxt = ptr + CH_PTR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/channel_free_pick.sv
// Combinational first-free search: rotate the free mask so the start pointer
// sits at position 0, then priority-encode the lowest set position.
module channel_free_pick
  import channel_entry_alloc_pkg::*;
(
  input  logic [CH_ENTRY_NUM-1:0] free_mask,
  input  logic [CH_PTR_W-1:0]     start_ptr,
  output logic [CH_PTR_W-1:0]     entry_id,
  output logic                    found
);

  logic [CH_ENTRY_NUM-1:0] rotated_s;
  logic [CH_PTR_W-1:0]     id_lut_s [CH_ENTRY_NUM];
  logic [CH_PTR_W-1:0]     idx_s;

  // Rotate the mask from the start pointer and remember each slot's real entry id.
  always_comb begin
    rotated_s = {CH_ENTRY_NUM{1'b0}};
    for (int i = 0; i < CH_ENTRY_NUM; i++) begin
      id_lut_s[i] = {CH_PTR_W{1'b0}};
    end
    if (start_ptr > CH_PTR_W'(CH_ENTRY_NUM - 1)) begin
      idx_s = {CH_PTR_W{1'b0}};
    end else begin
      idx_s = start_ptr;
    end
    for (int i = 0; i < CH_ENTRY_NUM; i++) begin
      rotated_s[i] = free_mask[idx_s];
      id_lut_s[i]  = idx_s;
      idx_s        = ptr_inc(idx_s);
    end
  end

  // Lowest rotated position wins; scanning downward leaves the lowest hit last.
  always_comb begin
    entry_id = {CH_PTR_W{1'b0}};
    found    = 1'b0;
    for (int i = CH_ENTRY_NUM - 1; i >= 0; i--) begin
      if (rotated_s[i]) begin
        entry_id = id_lut_s[i];
        found    = 1'b1;
      end else begin
        entry_id = entry_id;
        found    = found;
      end
    end
  end

endmodule

// File: rtl/channel_entry_alloc.sv
// Five-entry channel allocator: writes claim the first free entry from a
// rotating write pointer, releases free an entry and move the read pointer.
module channel_entry_alloc
  import channel_entry_alloc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             wr_valid_i,
  input  logic [DATA_W-1:0]                wr_data_i,
  output logic                             wr_ready_o,
  input  logic                             rel_valid_i,
  input  logic [CH_PTR_W-1:0]              rel_id_i,
  output logic [CH_ENTRY_NUM-1:0]          channel_array_valid_o,
  output logic [CH_PTR_W-1:0]              read_ptr_o,
  output logic [CH_ENTRY_NUM-1:0]          read_ptr_dcd_o,
  output logic [CH_ENTRY_NUM*DATA_W-1:0]   entry_data_o,
  output logic [CH_PTR_W-1:0]              count_o
);

  logic [CH_ENTRY_NUM-1:0] valid_r;
  logic [DATA_W-1:0]       payload_r [CH_ENTRY_NUM];
  logic [CH_PTR_W-1:0]     wr_ptr_r;
  logic [CH_PTR_W-1:0]     read_ptr_r;
  logic [CH_PTR_W-1:0]     count_r;

  logic [CH_ENTRY_NUM-1:0] free_s;
  logic [CH_ENTRY_NUM-1:0] valid_nxt_s;
  logic [CH_PTR_W-1:0]     pick_id_s;
  logic                    pick_found_s;
  logic                    wr_fire_s;
  logic                    rel_hit_s;
  logic                    rel_fire_s;

  assign free_s = ~valid_r;

  channel_free_pick u_free_pick (
    .free_mask (free_s),
    .start_ptr (wr_ptr_r),
    .entry_id  (pick_id_s),
    .found     (pick_found_s)
  );

  // Handshake and release qualification, from current state only (no release bypass).
  always_comb begin
    wr_ready_o = |free_s;
    wr_fire_s  = wr_valid_i & wr_ready_o & pick_found_s;
    rel_hit_s  = 1'b0;
    for (int k = 0; k < CH_ENTRY_NUM; k++) begin
      rel_hit_s = rel_hit_s | ((rel_id_i == CH_PTR_W'(k)) & valid_r[k]);
    end
    rel_fire_s = rel_valid_i & rel_hit_s;
  end

  // Next valid vector: set the allocated entry, clear the released one.
  always_comb begin
    valid_nxt_s = valid_r;
    for (int k = 0; k < CH_ENTRY_NUM; k++) begin
      if (wr_fire_s && (pick_id_s == CH_PTR_W'(k))) begin
        valid_nxt_s[k] = 1'b1;
      end else if (rel_fire_s && (rel_id_i == CH_PTR_W'(k))) begin
        valid_nxt_s[k] = 1'b0;
      end else begin
        valid_nxt_s[k] = valid_r[k];
      end
    end
  end

  // State registers: valid flags, payloads, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r    <= {CH_ENTRY_NUM{1'b0}};
      wr_ptr_r   <= {CH_PTR_W{1'b0}};
      read_ptr_r <= {CH_PTR_W{1'b0}};
      count_r    <= {CH_PTR_W{1'b0}};
      for (int k = 0; k < CH_ENTRY_NUM; k++) begin
        payload_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      valid_r <= valid_nxt_s;
      for (int k = 0; k < CH_ENTRY_NUM; k++) begin
        if (wr_fire_s && (pick_id_s == CH_PTR_W'(k))) begin
          payload_r[k] <= wr_data_i;
        end
      end
      if (wr_fire_s) begin
        wr_ptr_r <= ptr_inc(pick_id_s);
      end
      if (rel_fire_s) begin
        read_ptr_r <= ptr_inc(rel_id_i);
      end
      case ({wr_fire_s, rel_fire_s})
        2'b10:   count_r <= count_r + CH_PTR_W'(1);
        2'b01:   count_r <= count_r - CH_PTR_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output mapping: decoded read pointer and flattened payloads.
  always_comb begin
    channel_array_valid_o = valid_r;
    read_ptr_o            = read_ptr_r;
    read_ptr_dcd_o        = CH_ENTRY_NUM'(1) << read_ptr_r;
    count_o               = count_r;
    entry_data_o          = {(CH_ENTRY_NUM*DATA_W){1'b0}};
    for (int k = 0; k < CH_ENTRY_NUM; k++) begin
      entry_data_o[k*DATA_W +: DATA_W] = payload_r[k];
    end
  end

endmodule

// File: tb/tb_channel_entry_alloc.sv
// Directed and randomized checks of channel_entry_alloc against a slot-array model.
module tb_channel_entry_alloc;

  localparam int DW = 32;
  localparam int N  = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_ready;
  logic            rel_valid = 1'b0;
  logic [2:0]      rel_id = '0;
  logic [N-1:0]    valid_o;
  logic [2:0]      read_ptr;
  logic [N-1:0]    read_ptr_dcd;
  logic [N*DW-1:0] entry_data;
  logic [2:0]      count;

  int tests = 0;
  int fails = 0;

  // Reference model: plain slot arrays and integer pointers.
  bit          m_valid [N];
  logic [DW-1:0] m_data [N];
  int          m_wptr;
  int          m_rptr;

  channel_entry_alloc #(.DATA_W(DW)) dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .wr_valid_i            (wr_valid),
    .wr_data_i             (wr_data),
    .wr_ready_o            (wr_ready),
    .rel_valid_i           (rel_valid),
    .rel_id_i              (rel_id),
    .channel_array_valid_o (valid_o),
    .read_ptr_o            (read_ptr),
    .read_ptr_dcd_o        (read_ptr_dcd),
    .entry_data_o          (entry_data),
    .count_o               (count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_wptr = 0;
    m_rptr = 0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_valid[i] ? 1 : 0;
    return c;
  endfunction

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    ev = '0;
    ed = '0;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_valid[i];
      ed[i*DW +: DW] = m_data[i];
    end
    check({tag, ".valid"}, valid_o, ev);
    check({tag, ".rptr"},  read_ptr, m_rptr);
    check({tag, ".dcd"},   read_ptr_dcd, 5'b00001 << m_rptr);
    check({tag, ".count"}, count, model_count());
    check({tag, ".data"},  entry_data, ed);
    check({tag, ".ready"}, wr_ready, (model_count() < N) ? 1 : 0);
  endtask

  // One clock of stimulus; ready checked before the edge, state after it.
  task automatic step(input string tag, input bit wv, input logic [DW-1:0] wd,
                      input bit rv, input logic [2:0] rid);
    bit found;
    int sel;
    bit rel_ok;
    @(negedge clk);
    wr_valid  = wv;
    wr_data   = wd;
    rel_valid = rv;
    rel_id    = rid;
    #1;
    check({tag, ".ready_pre"}, wr_ready, (model_count() < N) ? 1 : 0);
    found = 1'b0;
    sel = 0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_wptr + i) % N;
      if (!found && !m_valid[j]) begin
        found = 1'b1;
        sel = j;
      end
    end
    rel_ok = rv && (rid <= 3'd4) && m_valid[rid];
    @(posedge clk);
    #1;
    if (rel_ok) begin
      m_valid[rid] = 1'b0;
      m_rptr = (rid + 1) % N;
    end
    if (wv && found) begin
      m_valid[sel] = 1'b1;
      m_data[sel]  = wd;
      m_wptr = (sel + 1) % N;
    end
    wr_valid  = 1'b0;
    rel_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Five back-to-back writes fill entries 0..4.
    for (int i = 0; i < N; i++) begin
      step("fill", 1'b1, 32'hD000_0000 + i, 1'b0, 3'd0);
      check("fill.entry", entry_data[i*DW +: DW], 32'hD000_0000 + i);
      check("fill.cnt", count, i + 1);
    end
    check("full.ready", wr_ready, 1'b0);

    // Release id 2 while full: ready low that cycle, high after.
    step("rel2", 1'b1, 32'hBAD0_BAD0, 1'b1, 3'd2);
    check("rel2.valid", valid_o, 5'b11011);
    check("rel2.dcd", read_ptr_dcd, 5'b01000);

    // Write lands in entry 2 (first free from wr_ptr 0).
    step("wrX", 1'b1, 32'hAAAA_5555, 1'b0, 3'd0);
    check("wrX.entry2", entry_data[2*DW +: DW], 32'hAAAA_5555);

    // Build valid=10111 then write + release 4 together.
    step("rel3", 1'b0, '0, 1'b1, 3'd3);
    check("rel3.valid", valid_o, 5'b10111);
    step("wr_rel4", 1'b1, 32'h1234_5678, 1'b1, 3'd4);
    check("wr_rel4.valid", valid_o, 5'b01111);
    check("wr_rel4.cnt", count, 3'd4);
    check("wr_rel4.rptr", read_ptr, 3'd0);

    // Ignored releases: out of range, then a free entry.
    step("rel6", 1'b0, '0, 1'b1, 3'd6);
    step("relfree", 1'b0, '0, 1'b1, 3'd4);
    check("relfree.valid", valid_o, 5'b01111);

    // Bring occupancy to 3, then reset asynchronously mid-cycle.
    step("pre_rst", 1'b0, '0, 1'b1, 3'd0);
    check("pre_rst.cnt", count, 3'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 32'hCAFE_F00D, 1'b0, 3'd0);
    check("post_rst.valid", valid_o, 5'b00001);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 45),
           3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
